// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with generic exponent and fraction widths,
// valid/ready backpressure, a sideband tag, round-to-nearest-even and IEEE-style special values.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op_sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 flag_invalid,
    output logic                 flag_overflow,
    output logic                 flag_inexact
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;          // significand with hidden bit
    localparam int AW = MAN_W + 3;          // aligned significand plus guard and round
    localparam int FW = MAN_W + 4;          // aligned significand plus guard, round, sticky
    localparam int EW = EXP_W + 2;          // signed working exponent
    localparam logic [EXP_W-1:0]        EXP_ONES = '1;
    localparam logic signed [EW-1:0]    EMAX     = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic int lzc(input logic [FW-1:0] v);
        int n;
        n = FW;
        for (int i = 0; i < FW; i++)
            if (v[i]) n = FW - 1 - i;
        return n;
    endfunction

    function automatic logic [SW:0] round_rne(input logic [FW-1:0] n);
        logic up;
        up = n[2] & (n[3] | n[1] | n[0]);
        return {1'b0, n[FW-1:3]} + {{SW{1'b0}}, up};
    endfunction

    // Returns {overflow, inexact, packed word}; out-of-range exponents saturate to inf or flush to zero.
    function automatic logic [W+1:0] saturate_pack(input logic sign, input logic signed [EW-1:0] e,
                                                   input logic [MAN_W-1:0] frac, input logic inexact);
        if (e >= EMAX)
            return {2'b11, sign, EXP_ONES, {MAN_W{1'b0}}};
        if (e[EW-1] || e == '0)
            return {2'b01, sign, {(EXP_W+MAN_W){1'b0}}};
        return {1'b0, inexact, sign, e[EXP_W-1:0], frac};
    endfunction

    logic stall, adv;
    logic vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;

    assign stall    = vld_p4 && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // ---- p0: input capture ----
    logic [W-1:0]     a_p0, b_p0;
    logic             sub_p0;
    logic [TAG_W-1:0] tag_p0;

    always_ff @(posedge clk) begin
        if (adv) begin
            a_p0   <= a;
            b_p0   <= b;
            sub_p0 <= op_sub;
            tag_p0 <= in_tag;
        end
    end

    // ---- S1: unpack, classify, order by magnitude ----
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic             spec_any, spec_inv;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [W-1:0]     spec_res;

    always_comb begin
        sa       = a_p0[W-1];
        ea       = a_p0[W-2:MAN_W];
        sb       = b_p0[W-1] ^ sub_p0;
        eb       = b_p0[W-2:MAN_W];
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        fa       = a_zero ? '0 : a_p0[MAN_W-1:0];
        fb       = b_zero ? '0 : b_p0[MAN_W-1:0];
        a_inf    = (ea == EXP_ONES) && (fa == '0);
        b_inf    = (eb == EXP_ONES) && (fb == '0);
        a_nan    = (ea == EXP_ONES) && (fa != '0);
        b_nan    = (eb == EXP_ONES) && (fb != '0);
        swap     = {eb, fb} > {ea, fa};
        spec_any = a_nan | b_nan | a_inf | b_inf;
        spec_inv = 1'b0;
        spec_res = QNAN;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if (a_inf && b_inf) begin
            if (sa != sb) spec_inv = 1'b1;
            else          spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_inf) begin
            spec_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             sx_p1, eff_sub_p1, zsign_p1, spec_p1, inv_p1;
    logic [EXP_W-1:0] ex_p1, d_p1;
    logic [SW-1:0]    sigx_p1, sigy_p1;
    logic [W-1:0]     spres_p1;
    logic [TAG_W-1:0] tag_p1;

    always_ff @(posedge clk) begin
        if (adv) begin
            sx_p1      <= swap ? sb : sa;
            ex_p1      <= swap ? eb : ea;
            sigx_p1    <= swap ? {~b_zero, fb} : {~a_zero, fa};
            sigy_p1    <= swap ? {~a_zero, fa} : {~b_zero, fb};
            d_p1       <= swap ? eb - ea : ea - eb;
            eff_sub_p1 <= sa ^ sb;
            zsign_p1   <= sa & sb;
            spec_p1    <= spec_any;
            inv_p1     <= spec_inv;
            spres_p1   <= spec_res;
            tag_p1     <= tag_p0;
        end
    end

    // ---- S2: align the smaller operand ----
    logic [2*AW-1:0] wide;
    logic [AW-1:0]   yal;
    logic            ysticky;

    always_comb begin
        wide    = {sigy_p1, 2'b00, {AW{1'b0}}} >> d_p1;
        yal     = wide[2*AW-1:AW];
        ysticky = |wide[AW-1:0];
        if (int'(d_p1) >= AW) begin
            yal     = '0;
            ysticky = |sigy_p1;
        end
    end

    logic             sx_p2, eff_sub_p2, zsign_p2, spec_p2, inv_p2;
    logic [EXP_W-1:0] ex_p2;
    logic [FW-1:0]    xext_p2, yext_p2;
    logic [W-1:0]     spres_p2;
    logic [TAG_W-1:0] tag_p2;

    always_ff @(posedge clk) begin
        if (adv) begin
            sx_p2      <= sx_p1;
            ex_p2      <= ex_p1;
            xext_p2    <= {sigx_p1, 3'b000};
            yext_p2    <= {yal, ysticky};
            eff_sub_p2 <= eff_sub_p1;
            zsign_p2   <= zsign_p1;
            spec_p2    <= spec_p1;
            inv_p2     <= inv_p1;
            spres_p2   <= spres_p1;
            tag_p2     <= tag_p1;
        end
    end

    // ---- S3: add or subtract, normalise ----
    logic [FW:0]            sum;
    logic [FW-1:0]          diff, norm;
    logic signed [EW-1:0]   ex_s, e_n;
    logic                   zero;
    int                     lz;

    always_comb begin
        ex_s = signed'({2'b00, ex_p2});
        sum  = {1'b0, xext_p2} + {1'b0, yext_p2};
        diff = xext_p2 - yext_p2;
        lz   = lzc(diff);
        norm = sum[FW-1:0];
        e_n  = ex_s;
        zero = (sum == '0);
        if (eff_sub_p2) begin
            norm = diff << lz;
            e_n  = ex_s - signed'(EW'(lz));
            zero = (diff == '0);
        end else if (sum[FW]) begin
            norm = {sum[FW:2], sum[1] | sum[0]};
            e_n  = ex_s + signed'({{(EW-1){1'b0}}, 1'b1});
        end
    end

    logic                 sx_p3, zero_p3, zsign_p3, spec_p3, inv_p3;
    logic signed [EW-1:0] e_p3;
    logic [FW-1:0]        norm_p3;
    logic [W-1:0]         spres_p3;
    logic [TAG_W-1:0]     tag_p3;

    always_ff @(posedge clk) begin
        if (adv) begin
            sx_p3    <= sx_p2;
            e_p3     <= e_n;
            norm_p3  <= norm;
            zero_p3  <= zero;
            zsign_p3 <= zsign_p2;
            spec_p3  <= spec_p2;
            inv_p3   <= inv_p2;
            spres_p3 <= spres_p2;
            tag_p3   <= tag_p2;
        end
    end

    // ---- S4: round, pack, resolve specials ----
    logic [SW:0]          rm;
    logic signed [EW-1:0] e_r;
    logic [MAN_W-1:0]     frac;
    logic [W+1:0]         pk;
    logic [W-1:0]         res_d;
    logic                 inv_d, ovf_d, inx_d;

    always_comb begin
        rm    = round_rne(norm_p3);
        e_r   = e_p3 + signed'({{(EW-1){1'b0}}, rm[SW]});
        frac  = rm[SW] ? rm[MAN_W:1] : rm[MAN_W-1:0];
        pk    = saturate_pack(sx_p3, e_r, frac, |norm_p3[2:0]);
        res_d = pk[W-1:0];
        ovf_d = pk[W+1];
        inx_d = pk[W];
        inv_d = 1'b0;
        if (spec_p3) begin
            res_d = spres_p3;
            inv_d = inv_p3;
            ovf_d = 1'b0;
            inx_d = 1'b0;
        end else if (zero_p3) begin
            res_d = {zsign_p3, {(W-1){1'b0}}};
            ovf_d = 1'b0;
            inx_d = 1'b0;
        end
    end

    logic [W-1:0]     res_p4;
    logic [TAG_W-1:0] tag_p4;
    logic             inv_p4, ovf_p4, inx_p4;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p4 <= 1'b0;
            res_p4 <= '0;
            tag_p4 <= '0;
            inv_p4 <= 1'b0;
            ovf_p4 <= 1'b0;
            inx_p4 <= 1'b0;
        end else if (adv) begin
            vld_p4 <= vld_p3;
            res_p4 <= res_d;
            tag_p4 <= tag_p3;
            inv_p4 <= inv_d;
            ovf_p4 <= ovf_d;
            inx_p4 <= inx_d;
        end
    end

    assign out_valid     = vld_p4;
    assign result        = res_p4;
    assign out_tag       = tag_p4;
    assign flag_invalid  = inv_p4;
    assign flag_overflow = ovf_p4;
    assign flag_inexact  = inx_p4;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: single precision instance plus a half-precision instance.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  in_tag, out_tag;
    logic        flag_invalid, flag_overflow, flag_inexact;

    logic        in_valid2, in_ready2, op_sub2, out_valid2, out_ready2;
    logic [15:0] a2, b2, result2;
    logic [3:0]  in_tag2, out_tag2;
    logic        flag_invalid2, flag_overflow2, flag_inexact2;

    fp_addsub_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_inexact(flag_inexact)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .op_sub(op_sub2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .out_tag(out_tag2),
        .flag_invalid(flag_invalid2), .flag_overflow(flag_overflow2), .flag_inexact(flag_inexact2)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flags;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] va;
        logic [31:0] vb;
        logic        sub;
        logic [31:0] res;
        logic [2:0]  fl;   // {invalid, overflow, inexact}
    } vec_t;

    exp_t q[$];
    exp_t q2[$];
    exp_t e1, e2;
    vec_t vecs [0:18];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input logic [3:0] tg, input logic [31:0] er, input logic [2:0] ef,
                         input bit lat, input bit push, input bit d2);
        bit   rdy;
        bit   done;
        int   w;
        exp_t e;
        if (!d2) begin
            a = av; b = bv; op_sub = sv; in_tag = tg; in_valid = 1'b1;
        end else begin
            a2 = av[15:0]; b2 = bv[15:0]; op_sub2 = sv; in_tag2 = tg; in_valid2 = 1'b1;
        end
        w = 0; done = 0; rdy = 0;
        while (!done) begin
            @(negedge clk);
            rdy = d2 ? in_ready2 : in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
            else begin
                w++;
                if (w > 50) begin
                    n_checks++; n_fail++;
                    $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", w);
                    done = 1;
                end
            end
        end
        if (rdy && push) begin
            e.res = er; e.tag = tg; e.flags = ef; e.acc = cyc; e.lat = lat;
            if (d2) q2.push_back(e);
            else    q.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || q2.size() != 0) && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor for the single-precision instance
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h tag %0d, required no output", result, out_tag);
            end else if (out_ready) begin
                e1 = q.pop_front();
                check("result", 64'(result), 64'(e1.res));
                check("out_tag", 64'(out_tag), 64'(e1.tag));
                check("flags", 64'({flag_invalid, flag_overflow, flag_inexact}), 64'(e1.flags));
                if (e1.lat) check("latency", 64'(cyc - e1.acc), 64'd4);
            end else begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_result", 64'(result), 64'(q[0].res));
                check("stall_tag", 64'(out_tag), 64'(q[0].tag));
            end
        end
    end

    // Monitor for the half-precision instance
    always @(negedge clk) begin
        if (out_valid2) begin
            if (q2.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_output_h: got result 0x%0h, required no output", result2);
            end else if (out_ready2) begin
                e2 = q2.pop_front();
                check("result_h", 64'(result2), 64'(e2.res[15:0]));
                check("out_tag_h", 64'(out_tag2), 64'(e2.tag));
                check("flags_h", 64'({flag_invalid2, flag_overflow2, flag_inexact2}), 64'(e2.flags));
                if (e2.lat) check("latency_h", 64'(cyc - e2.acc), 64'd4);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
        vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
        vecs[3]  = '{32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 3'b000};
        vecs[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
        vecs[5]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
        vecs[8]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
        vecs[9]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000};
        vecs[10] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000};
        vecs[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
        vecs[12] = '{32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000};
        vecs[13] = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000};
        vecs[14] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001};
        vecs[15] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001};
        vecs[16] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001};
        vecs[17] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000};
        vecs[18] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000};

        reset = 1'b1; in_valid = 0; a = 0; b = 0; op_sub = 0; in_tag = 0; out_ready = 1'b1;
        in_valid2 = 0; a2 = 0; b2 = 0; op_sub2 = 0; in_tag2 = 0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_flags", 64'({flag_invalid, flag_overflow, flag_inexact}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors back to back with out_ready held high
        for (int i = 0; i < 19; i++)
            issue(vecs[i].va, vecs[i].vb, vecs[i].sub, 4'((i + 3) % 16), vecs[i].res, vecs[i].fl, 1, 1, 0);
        idle();
        drain();

        // Backpressure: six operations, out_ready dropped for three cycles after the first result
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(vecs[i].va, vecs[i].vb, vecs[i].sub, 4'(i), vecs[i].res, vecs[i].fl, 0, 1, 0);
                idle();
            end
            begin
                int w;
                bit seen;
                w = 0; seen = 0;
                while (!seen && w < 40) begin
                    @(negedge clk);
                    if (out_valid) seen = 1;
                    w++;
                end
                if (!seen) begin
                    n_checks++; n_fail++;
                    $display("FAIL first_result_timeout: out_valid low for %0d cycles, required high", w);
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight: none of them may emerge
        for (int i = 0; i < 3; i++)
            issue(vecs[i].va, vecs[i].vb, vecs[i].sub, 4'(8 + i), vecs[i].res, vecs[i].fl, 0, 0, 0);
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_result", 64'(result), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("midrst_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        issue(vecs[0].va, vecs[0].vb, vecs[0].sub, 4'd3, vecs[0].res, vecs[0].fl, 1, 1, 0);
        idle();

        // Half precision: 1.0 + 2.0
        issue(32'h00003C00, 32'h00004000, 1'b0, 4'd3, 32'h00004200, 3'b000, 1, 1, 1);
        idle();
        drain();

        check("scoreboard_empty", 64'(q.size() + q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
